ccff_bitstream_loader: RTL and testbench
========================================

CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 8, bitstream word width in bits.
REQ-002 SHALL have parameter CHAIN_LEN, default 64, number of configuration flip-flops in the downstream chain.
REQ-003 SHALL have derived constant CNT_W = clog2(CHAIN_LEN+1).
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports as listed in REQ-005 and REQ-006.
REQ-005 SHALL have port prog_clk, input, 1, programming clock; all state updates on its rising edge.
REQ-006 SHALL have port pReset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, single-cycle request to begin a load session.
REQ-008 SHALL have port bs_data, input, WORD_W, bitstream word, MSB shifted first.
REQ-009 SHALL have port bs_valid, input, 1, bs_data valid.
REQ-010 SHALL have port bs_ready, output, 1, loader accepts a word this cycle.
REQ-011 SHALL have port ccff_head, output, 1, serial bit into the chain head.
REQ-012 SHALL have port ccff_shift_en, output, 1, enable for the external chain clock gate; high only when ccff_head carries a valid bit.
REQ-013 SHALL have port ccff_tail, input, 1, serial bit returning from the chain tail.
REQ-014 SHALL have port tail_q, output, 1, last ccff_tail value sampled on a shift cycle.
REQ-015 SHALL have port busy, output, 1, load session in progress.
REQ-016 SHALL have port done, output, 1, level, exactly CHAIN_LEN bits shifted.
REQ-017 SHALL have port bit_cnt, output, CNT_W, bits shifted this session.
REQ-018 SHALL have port err, output, 1, sticky, start received while busy.

Function
REQ-019 SHALL implement states IDLE, LOAD and DONE.
REQ-020 On start in IDLE or DONE, the block SHALL enter LOAD on the next cycle, clear bit_cnt, done and err, and set busy.
REQ-021 In LOAD, bs_ready SHALL be high when the word buffer is empty, or when its last remaining bit shifts this cycle and bit_cnt+1 < CHAIN_LEN.
REQ-022 A word SHALL be accepted only on a cycle where bs_valid and bs_ready are both high.
REQ-023 The first bit of an accepted word SHALL appear on ccff_head, with ccff_shift_en high, in the cycle after acceptance.
REQ-024 Each cycle the buffer is non-empty in LOAD, the block SHALL present the next MSB-first bit, assert ccff_shift_en, and increment bit_cnt at the end of the cycle.
REQ-025 With bs_valid held high, throughput SHALL be one bit per cycle with no bubbles between words.
REQ-026 If the buffer is empty and bs_valid is low, ccff_shift_en SHALL be 0 and ccff_head SHALL be 0 (chain holds), with no error raised.
REQ-027 When the CHAIN_LEN-th bit shifts, the block SHALL enter DONE on the next cycle, set done=1, clear busy, and discard unshifted bits of the final word.
REQ-028 When CHAIN_LEN is not a multiple of WORD_W, only the top (CHAIN_LEN mod WORD_W) bits of the final word SHALL be used.
REQ-029 tail_q SHALL update from ccff_tail only on cycles where ccff_shift_en=1.
REQ-030 start while busy SHALL be ignored and SHALL set err, which holds until pReset or an accepted start.
REQ-031 bs_ready SHALL be 0 in IDLE and DONE.
REQ-032 bs_data and bs_valid presented in IDLE or DONE SHALL be ignored.
REQ-033 ccff_head and ccff_shift_en SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-034 pReset SHALL force state IDLE, buffer empty, bit_cnt=0, ccff_head=0, ccff_shift_en=0, tail_q=0, busy=0, done=0, err=0 and bs_ready=0.
REQ-035 pReset during LOAD SHALL abort the session on the next edge; a partially shifted chain is not restored.
REQ-036 pReset SHALL take priority over start on the same cycle.

Structure
REQ-037 Package ccff_loader_pkg SHALL hold the state enumeration and the CNT_W derivation function.
REQ-038 Sub-module ccff_word_serializer SHALL contain the word buffer, bits-left counter and MSB-first shift.
REQ-039 The top level SHALL hold the FSM, bit_cnt, err and tail_q.

Verification
REQ-040 CHAIN_LEN=16, WORD_W=8; start, then words 0xA5 and 0x3C back-to-back -> ccff_head sequence 1010010100111100 on 16 consecutive shift_en cycles, done=1, bit_cnt=16.
REQ-041 CHAIN_LEN=12; words 0xFF and 0xF0 -> 12 shift cycles, last 4 bits of 0xF0 discarded, bs_ready never high after the second word.
REQ-042 bs_valid low for 5 cycles between words -> shift_en=0 for those cycles, bit_cnt frozen, final stream unchanged.
REQ-043 start pulsed at bit_cnt=5 -> err=1, session completes normally; next accepted start -> err=0.
REQ-044 pReset at bit_cnt=9 -> next cycle all outputs at reset values; a new start reloads from bit 0.
REQ-045 Chain model of CHAIN_LEN flops; load pattern P1 then P2 -> tail_q stream during the second load equals P1 MSB-first.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and width helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } ldr_state_e;

   // Bits needed to hold every value 0..max_val, i.e. clog2(max_val+1).
   function automatic int cnt_width(input int max_val);
      int w;
      w = 1;
      while ((1 << w) <= max_val) w++;
      return w;
   endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer that turns accepted bitstream words into an MSB-first serial stream.
module ccff_word_serializer
   import ccff_loader_pkg::*;
#(
   parameter int WORD_W = 8,
   localparam int LEFT_W = cnt_width(WORD_W)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_en_i,
   input  logic              flush_i,
   input  logic              more_ok_i,
   input  logic [WORD_W-1:0] word_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              head_o,
   output logic              shift_en_o
);
   localparam logic [LEFT_W-1:0] FULL = LEFT_W'(WORD_W);
   localparam logic [LEFT_W-1:0] ONE  = LEFT_W'(1);

   logic [WORD_W-1:0] word_q, word_d;
   logic [LEFT_W-1:0] left_q, left_d;
   logic              head_q, head_d;
   logic              shift_q, shift_d;

   // left_q counts bits still owed to the chain, including the one on head_o now.
   always_comb begin
      ready_o = load_en_i && ((left_q == '0) || ((left_q == ONE) && more_ok_i));
      word_d  = word_q;
      left_d  = left_q;
      if (flush_i) begin
         word_d = '0;
         left_d = '0;
      end else if (valid_i && ready_o) begin
         word_d = word_i;
         left_d = FULL;
      end else if (left_q != '0) begin
         word_d = word_q << 1;
         left_d = left_q - ONE;
      end
      shift_d = (left_d != '0);
      head_d  = shift_d & word_d[WORD_W-1];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         word_q  <= '0;
         left_q  <= '0;
         head_q  <= 1'b0;
         shift_q <= 1'b0;
      end else begin
         word_q  <= word_d;
         left_q  <= left_d;
         head_q  <= head_d;
         shift_q <= shift_d;
      end
   end

   assign head_o     = head_q;
   assign shift_en_o = shift_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Loads a configuration flip-flop chain from a word stream; owns session FSM, bit count, error and tail sample.
//  state   | meaning
//  IDLE    | no session since reset, waiting for start
//  LOAD    | shifting words into the chain
//  DONE    | CHAIN_LEN bits shifted, waiting for next start
module ccff_bitstream_loader
   import ccff_loader_pkg::*;
#(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 64,
   localparam int CNT_W    = cnt_width(CHAIN_LEN)
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              tail_q,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  bit_cnt,
   output logic              err
);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] CHAIN_MAX = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   ldr_state_e       state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             err_q, err_d;
   logic             tail_bit_q, tail_bit_d;
   logic             start_acc, err_set, last_shift, more_ok, in_load, flush;

   always_comb begin
      state_d    = state_q;
      start_acc  = 1'b0;
      err_set    = 1'b0;
      in_load    = (state_q == ST_LOAD);
      last_shift = ccff_shift_en && (bit_cnt_q == LAST_IDX);
      more_ok    = (bit_cnt_q + ONE) < CHAIN_MAX;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_LOAD;
               start_acc = 1'b1;
            end
         end
         ST_LOAD: begin
            if (last_shift) state_d = ST_DONE;
            if (start) err_set = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      flush = last_shift || start_acc;

      bit_cnt_d = bit_cnt_q;
      if (start_acc) bit_cnt_d = '0;
      else if (ccff_shift_en) bit_cnt_d = bit_cnt_q + ONE;

      err_d = err_q;
      if (start_acc) err_d = 1'b0;
      else if (err_set) err_d = 1'b1;

      tail_bit_d = ccff_shift_en ? ccff_tail : tail_bit_q;
   end

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         err_q      <= 1'b0;
         tail_bit_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         err_q      <= err_d;
         tail_bit_q <= tail_bit_d;
      end
   end

   ccff_word_serializer #(
      .WORD_W (WORD_W)
   ) u_ser (
      .clk_i      (prog_clk),
      .rst_i      (pReset),
      .load_en_i  (in_load),
      .flush_i    (flush),
      .more_ok_i  (more_ok),
      .word_i     (bs_data),
      .valid_i    (bs_valid),
      .ready_o    (bs_ready),
      .head_o     (ccff_head),
      .shift_en_o (ccff_shift_en)
   );

   assign busy    = (state_q == ST_LOAD);
   assign done    = (state_q == ST_DONE);
   assign bit_cnt = bit_cnt_q;
   assign err     = err_q;
   assign tail_q  = tail_bit_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: two instances (16- and 12-bit chains) with an external chain model.
module tb_ccff_bitstream_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       p_reset[2];
   logic       start[2];
   logic       bs_valid[2];
   logic [7:0] bs_data[2];
   logic       bs_ready[2];
   logic       head[2];
   logic       shift_en[2];
   logic       tail_q[2];
   logic       busy[2];
   logic       done[2];
   logic       err[2];
   logic [4:0] bc16;
   logic [3:0] bc12;
   logic [4:0] bcnt[2];
   logic       tail_in0, tail_in1;

   logic [15:0] chain0 = '0;
   logic [11:0] chain1 = '0;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] last_bits[2];
   bit          tail_known[2];
   logic [7:0]  wq[$];

   assign bcnt[0]  = bc16;
   assign bcnt[1]  = {1'b0, bc12};
   assign tail_in0 = chain0[15];
   assign tail_in1 = chain1[11];

   // external configuration chain: head enters bit 0, tail leaves the top bit
   always @(posedge clk) begin
      if (shift_en[0] === 1'b1) chain0 <= {chain0[14:0], head[0]};
      if (shift_en[1] === 1'b1) chain1 <= {chain1[10:0], head[1]};
   end

   ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(16)) u_dut16 (
      .prog_clk(clk), .pReset(p_reset[0]), .start(start[0]), .bs_data(bs_data[0]),
      .bs_valid(bs_valid[0]), .bs_ready(bs_ready[0]), .ccff_head(head[0]),
      .ccff_shift_en(shift_en[0]), .ccff_tail(tail_in0), .tail_q(tail_q[0]),
      .busy(busy[0]), .done(done[0]), .bit_cnt(bc16), .err(err[0])
   );

   ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(12)) u_dut12 (
      .prog_clk(clk), .pReset(p_reset[1]), .start(start[1]), .bs_data(bs_data[1]),
      .bs_valid(bs_valid[1]), .bs_ready(bs_ready[1]), .ccff_head(head[1]),
      .ccff_shift_en(shift_en[1]), .ccff_tail(tail_in1), .tail_q(tail_q[1]),
      .busy(busy[1]), .done(done[1]), .bit_cnt(bc12), .err(err[1])
   );

   function automatic int cl_of(input int idx);
      return (idx == 0) ? 16 : 12;
   endfunction

   task automatic load_random_words();
      wq.delete();
      wq.push_back(8'($urandom));
      wq.push_back(8'($urandom));
   endtask

   // One load session; expected stream is the word list laid out MSB-first and cut at the chain length.
   task automatic run_session(input int idx, input int gap_len, input int err_at, input int abort_at);
      int cl, n_got, n_tail, k, wi, acc_bits, cyc, first, last, gap_left, bubbles;
      logic [15:0] exp_v, got_v, tail_v;
      bit seen_prev, done_seen, aborted, err_pulsed, err_chk;
      cl = cl_of(idx);
      exp_v = '0; got_v = '0; tail_v = '0;
      n_got = 0; n_tail = 0; k = 0; wi = 0; acc_bits = 0; cyc = 0;
      first = -1; last = -1; gap_left = gap_len;
      seen_prev = 0; done_seen = 0; aborted = 0; err_pulsed = 0; err_chk = 0;
      foreach (wq[w]) begin
         for (int b = 7; b >= 0; b--) begin
            if (k < cl) exp_v[k] = wq[w][b];
            k++;
         end
      end

      @(negedge clk);
      start[idx] = 1'b1;
      bs_valid[idx] = 1'b0;
      @(negedge clk);
      start[idx] = 1'b0;
      n_cmp++;
      if (busy[idx] !== 1'b1 || done[idx] !== 1'b0 || err[idx] !== 1'b0 || bcnt[idx] !== 5'd0 ||
          bs_ready[idx] !== 1'b1 || shift_en[idx] !== 1'b0) begin
         n_bad++;
         $display("FAIL start_state dut%0d: busy=%b done=%b err=%b cnt=%0d ready=%b sh=%b, want 1 0 0 0 1 0",
                  idx, busy[idx], done[idx], err[idx], bcnt[idx], bs_ready[idx], shift_en[idx]);
      end

      while (cyc < 300) begin
         if (seen_prev && n_tail < 16) begin
            tail_v[n_tail] = tail_q[idx];
            n_tail++;
         end
         if (err_chk) begin
            err_chk = 0;
            n_cmp++;
            if (err[idx] !== 1'b1 || busy[idx] !== 1'b1) begin
               n_bad++;
               $display("FAIL err_set dut%0d: err=%b busy=%b, want 1 1", idx, err[idx], busy[idx]);
            end
         end
         if (done[idx] === 1'b1) begin
            done_seen = 1;
            break;
         end
         seen_prev = (shift_en[idx] === 1'b1);
         if (shift_en[idx] === 1'b1) begin
            n_cmp++;
            if (int'(bcnt[idx]) != n_got) begin
               n_bad++;
               $display("FAIL bit_cnt dut%0d: got %0d want %0d", idx, bcnt[idx], n_got);
            end
            if (n_got < 16) got_v[n_got] = head[idx];
            n_got++;
            if (first < 0) first = cyc;
            last = cyc;
         end else begin
            n_cmp++;
            if (head[idx] !== 1'b0) begin
               n_bad++;
               $display("FAIL head_hold dut%0d: head=%b want 0 while shift_en=0", idx, head[idx]);
            end
         end
         if (acc_bits >= cl) begin
            n_cmp++;
            if (bs_ready[idx] !== 1'b0) begin
               n_bad++;
               $display("FAIL ready_late dut%0d: ready=%b want 0 after %0d bits supplied", idx, bs_ready[idx], acc_bits);
            end
         end
         start[idx] = 1'b0;
         if (err_at >= 0 && !err_pulsed && int'(bcnt[idx]) == err_at) begin
            start[idx] = 1'b1;
            err_pulsed = 1;
            err_chk = 1;
         end
         if (abort_at >= 0 && int'(bcnt[idx]) == abort_at) begin
            bs_valid[idx] = 1'b0;
            p_reset[idx] = 1'b1;
            @(negedge clk);
            p_reset[idx] = 1'b0;
            n_cmp++;
            if (busy[idx] !== 1'b0 || done[idx] !== 1'b0 || err[idx] !== 1'b0 || bcnt[idx] !== 5'd0 ||
                head[idx] !== 1'b0 || shift_en[idx] !== 1'b0 || tail_q[idx] !== 1'b0 || bs_ready[idx] !== 1'b0) begin
               n_bad++;
               $display("FAIL abort_reset dut%0d: busy=%b done=%b err=%b cnt=%0d head=%b sh=%b tq=%b rdy=%b, want all 0",
                        idx, busy[idx], done[idx], err[idx], bcnt[idx], head[idx], shift_en[idx], tail_q[idx], bs_ready[idx]);
            end
            aborted = 1;
            break;
         end
         if (wi == 1 && gap_left > 0 && bs_ready[idx] === 1'b1) begin
            bs_valid[idx] = 1'b0;
            bs_data[idx]  = 8'($urandom);
            gap_left--;
         end else if (wi < wq.size()) begin
            bs_valid[idx] = 1'b1;
            bs_data[idx]  = wq[wi];
            if (bs_ready[idx] === 1'b1) begin
               wi++;
               acc_bits += 8;
            end
         end else begin
            bs_valid[idx] = 1'b0;
            bs_data[idx]  = 8'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      bs_valid[idx] = 1'b0;
      start[idx] = 1'b0;

      if (aborted) begin
         tail_known[idx] = 0;
         return;
      end
      n_cmp++;
      if (!done_seen) begin
         n_bad++;
         $display("FAIL timeout dut%0d: done not seen within 300 cycles", idx);
         return;
      end
      n_cmp++;
      if (n_got != cl || got_v !== exp_v) begin
         n_bad++;
         $display("FAIL stream dut%0d: got %0d bits %h want %0d bits %h (bit0 first)", idx, n_got, got_v, cl, exp_v);
      end
      n_cmp++;
      if (int'(bcnt[idx]) != cl || busy[idx] !== 1'b0 || bs_ready[idx] !== 1'b0 || shift_en[idx] !== 1'b0 ||
          done[idx] !== 1'b1 || err[idx] !== (err_at >= 0)) begin
         n_bad++;
         $display("FAIL done_state dut%0d: cnt=%0d busy=%b rdy=%b sh=%b done=%b err=%b, want %0d 0 0 0 1 %0d",
                  idx, bcnt[idx], busy[idx], bs_ready[idx], shift_en[idx], done[idx], err[idx], cl, (err_at >= 0));
      end
      bubbles = last - first + 1 - n_got;
      n_cmp++;
      if (bubbles != gap_len) begin
         n_bad++;
         $display("FAIL bubbles dut%0d: got %0d idle cycles want %0d", idx, bubbles, gap_len);
      end
      if (tail_known[idx]) begin
         n_cmp++;
         if (n_tail != cl || tail_v !== last_bits[idx]) begin
            n_bad++;
            $display("FAIL tail_stream dut%0d: got %0d bits %h want %h", idx, n_tail, tail_v, last_bits[idx]);
         end
      end
      last_bits[idx]  = got_v;
      tail_known[idx] = 1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         p_reset[i] = 1'b1; start[i] = 1'b1; bs_valid[i] = 1'b1; bs_data[i] = 8'hFF;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (busy[i] !== 1'b0 || done[i] !== 1'b0 || err[i] !== 1'b0 || bcnt[i] !== 5'd0 || head[i] !== 1'b0 ||
             shift_en[i] !== 1'b0 || tail_q[i] !== 1'b0 || bs_ready[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state dut%0d: busy=%b done=%b err=%b cnt=%0d head=%b sh=%b tq=%b rdy=%b, want all 0",
                     i, busy[i], done[i], err[i], bcnt[i], head[i], shift_en[i], tail_q[i], bs_ready[i]);
         end
         p_reset[i] = 1'b0; start[i] = 1'b0; bs_valid[i] = 1'b0;
      end
   endtask

   task automatic test_idle_ignore(input int idx, input int exp_cnt);
      for (int c = 0; c < 4; c++) begin
         bs_valid[idx] = 1'b1;
         bs_data[idx]  = 8'($urandom);
         @(negedge clk);
         n_cmp++;
         if (bs_ready[idx] !== 1'b0 || shift_en[idx] !== 1'b0 || busy[idx] !== 1'b0 || int'(bcnt[idx]) != exp_cnt) begin
            n_bad++;
            $display("FAIL idle_ignore dut%0d: rdy=%b sh=%b busy=%b cnt=%0d, want 0 0 0 %0d",
                     idx, bs_ready[idx], shift_en[idx], busy[idx], bcnt[idx], exp_cnt);
         end
      end
      bs_valid[idx] = 1'b0;
   endtask

   task automatic test_a5_3c();
      logic [15:0] exp_c;
      exp_c = 16'b1010010100111100;
      wq.delete();
      wq.push_back(8'hA5);
      wq.push_back(8'h3C);
      run_session(0, 0, -1, -1);
      for (int k = 0; k < 16; k++) begin
         n_cmp++;
         if (last_bits[0][k] !== exp_c[15-k]) begin
            n_bad++;
            $display("FAIL a5_3c_bit%0d: got %b want %b", k, last_bits[0][k], exp_c[15-k]);
         end
      end
   endtask

   task automatic test_truncate();
      wq.delete();
      wq.push_back(8'hFF);
      wq.push_back(8'hF0);
      run_session(1, 0, -1, -1);
      n_cmp++;
      if (last_bits[1] !== 16'h0FFF) begin
         n_bad++;
         $display("FAIL truncate12: got %h want 0fff", last_bits[1]);
      end
   endtask

   task automatic test_gap();
      load_random_words();
      run_session(0, 5, -1, -1);
      load_random_words();
      run_session(1, 5, -1, -1);
   endtask

   task automatic test_err_start();
      load_random_words();
      run_session(0, 0, 5, -1);
      load_random_words();
      run_session(0, 0, -1, -1);
   endtask

   task automatic test_abort();
      load_random_words();
      run_session(0, 0, -1, 9);
      load_random_words();
      run_session(0, 0, -1, -1);
      load_random_words();
      run_session(0, 0, -1, -1);
   endtask

   task automatic test_back_to_back();
      for (int s = 0; s < 8; s++) begin
         load_random_words();
         run_session(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1, -1);
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         p_reset[i] = 1'b1; start[i] = 1'b0; bs_valid[i] = 1'b0; bs_data[i] = 8'h00;
         last_bits[i] = '0; tail_known[i] = 0;
      end
      test_reset();
      test_idle_ignore(0, 0);
      test_idle_ignore(1, 0);
      test_a5_3c();
      test_truncate();
      test_idle_ignore(0, 16);
      test_idle_ignore(1, 12);
      test_gap();
      test_err_start();
      test_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
